// File: rtl/mac_vector_loader.sv
// Serial element loader and result register for the combinational vector MAC.
// Packs DATA_LENGTH (a, b) pairs into two operand vectors and registers the MAC result.
module mac_vector_loader #(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int DATA_LENGTH       = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [INPUT_DATA_WIDTH-1:0]              in_a,
  input  logic [INPUT_DATA_WIDTH-1:0]              in_b,
  output logic [INPUT_DATA_WIDTH*DATA_LENGTH-1:0]  mac_in_1,
  output logic [INPUT_DATA_WIDTH*DATA_LENGTH-1:0]  mac_in_2,
  input  logic [OUTPUT_DATA_WIDTH-1:0]             mac_out,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0]             out_data
);

  localparam int CNT_W = $clog2(DATA_LENGTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_LENGTH - 1);

  typedef enum logic {FILL, CAPTURE} state_t;

  state_t                       state, state_next;
  logic [CNT_W-1:0]             cnt, cnt_next;
  logic                         accept;
  logic                         capture;
  logic [INPUT_DATA_WIDTH-1:0]  bank_1 [DATA_LENGTH];
  logic [INPUT_DATA_WIDTH-1:0]  bank_2 [DATA_LENGTH];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (cnt == LAST) begin
            cnt_next   = '0;
            state_next = CAPTURE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      CAPTURE: begin
        // Buffer is frozen here, so mac_out has settled on the full vector.
        if (!out_valid || out_ready) begin
          capture    = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // NOTE: the banks are reset because they drive mac_in_* directly and must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DATA_LENGTH; k++) begin
        bank_1[k] <= '0;
        bank_2[k] <= '0;
      end
    end else if (accept) begin
      bank_1[cnt] <= in_a;
      bank_2[cnt] <= in_b;
    end
  end

  for (genvar k = 0; k < DATA_LENGTH; k++) begin : g_pack
    assign mac_in_1[k*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = bank_1[k];
    assign mac_in_2[k*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = bank_2[k];
  end

  // A capture in the same cycle as a consume keeps out_valid high with the new result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= mac_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mac_vector_loader.md
Name: mac_vector_loader

Overview:
- Upstream feeder and result register for the combinational fixed-point multiply-accumulate (MAC) stage in the attention datapath.
- Accepts element pairs (a, b) serially over a valid/ready stream and packs DATA_LENGTH pairs into the two packed operand vectors that drive the MAC.
- Registers the MAC's quantized result once per vector and presents it on a valid/ready output stream.
- Decouples the serial Q/K element streams from the single-shot vector MAC and provides backpressure.

Parameters:
- INPUT_DATA_WIDTH, 16, element width, fixed point, half integer / half fraction bits.
- OUTPUT_DATA_WIDTH, 16, MAC result width, fixed point, half integer / half fraction bits.
- DATA_LENGTH, 4, elements per vector; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  element pair on in_a/in_b is valid.
- in_ready  output  1  loader accepts an element pair this cycle.
- in_a  input  INPUT_DATA_WIDTH  element of operand vector 1.
- in_b  input  INPUT_DATA_WIDTH  element of operand vector 2.
- mac_in_1  output  INPUT_DATA_WIDTH*DATA_LENGTH  packed operand vector 1 to the MAC; element k in bits [W*(k+1)-1 : W*k].
- mac_in_2  output  INPUT_DATA_WIDTH*DATA_LENGTH  packed operand vector 2 to the MAC; same packing.
- mac_out  input  OUTPUT_DATA_WIDTH  combinational MAC result for the current mac_in_1/mac_in_2.
- out_valid  output  1  out_data holds an unconsumed result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  OUTPUT_DATA_WIDTH  registered dot-product result.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n); it is sampled only on the rising edge of clk.
- Reset, applied at any time including mid-fill or while a result is held:
  - state = FILL, element count = 0.
  - mac_in_1 = 0, mac_in_2 = 0.
  - out_valid = 0, out_data = 0.
  - Any partial vector or held result is discarded.
- Storage: one fill buffer (two DATA_LENGTH-entry register banks driving mac_in_1/mac_in_2 directly) and one result register (out_data).
- Element count: cnt, range 0..DATA_LENGTH-1, width $clog2(DATA_LENGTH).
- State machine, two states:
  - FILL: in_ready = 1. On in_valid && in_ready, write in_a into slot cnt of bank 1 and in_b into slot cnt of bank 2.
    - If cnt == DATA_LENGTH-1: cnt <= 0, state <= CAPTURE.
    - Otherwise: cnt <= cnt+1.
    - in_valid low: no change.
  - CAPTURE: in_ready = 0; the fill buffer is frozen, so mac_in_1/mac_in_2 are stable and mac_out is settled.
    - If !out_valid || out_ready: out_data <= mac_out, out_valid <= 1, state <= FILL.
    - Otherwise: remain in CAPTURE (stall) with buffers unchanged.
- Output handshake:
  - out_valid && out_ready with no simultaneous capture: out_valid <= 0.
  - Simultaneous consume and capture in the same cycle: out_valid stays 1 and out_data takes the new value. No bubble, no loss.
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Latency: last element accepted at edge T gives out_valid=1 after edge T+1 (visible in cycle T+1), when the output is free.
- Throughput: one vector per DATA_LENGTH+1 cycles with in_valid and out_ready held high.
- Overlap: the next vector begins filling in the cycle after capture, while the previous result may still be held.
- Width rules: no arithmetic in this block. Elements are stored bit-exact. mac_out is registered unmodified; quantization and saturation are the MAC's responsibility.
- Input side: in_a/in_b are ignored whenever in_valid=0 or in_ready=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_data=0, mac_in_1=mac_in_2=0; no element is written.
- Single vector, real MAC attached, DATA_LENGTH=4: feed a=b=0x0100 x4 back-to-back with out_ready=1 -> mac_in_1=mac_in_2=0x0100010001000100; out_valid rises one cycle after the 4th accept with out_data=0x0400; in_ready=0 only in the CAPTURE cycle.
- Ordering and sparsity: pairs (0x0200,0x0180), (0x0080,0x0080), (0,0x7FFF), (0x1234,0) with in_valid gaps of 0–3 cycles -> slot 0 = (0x0200,0x0180) in the LSBs; out_data=0x0340.
- Backpressure: out_ready=0, feed two full vectors (first result 0x0400) -> second vector stalls in CAPTURE with in_ready=0 and out_data held at 0x0400; raise out_ready -> 0x0400 consumed and the second result loaded in the same edge, out_valid continuously 1.
- Reset mid-fill: after 2 of 4 elements, pulse rst_n=0 for one cycle, then feed 4 fresh pairs of 0x0100 -> out_data=0x0400; no stale elements appear in mac_in_*.
- Streaming: 100 random vectors, in_valid/out_ready randomized at 50% -> results match a reference model in order, none dropped or duplicated, stable whenever out_valid && !out_ready.
